// File: rtl/dm9000a_pkg.sv
// rtl/dm9000a_pkg.sv - shared state encoding and framing constants for the DM9000A DPRAM loaders
package dm9000a_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_PAD  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam int MIN_FRAME   = 60;
    localparam int ADDR_W_DEF  = 10;
    localparam int FIFO_RD_LAT = 1;

endpackage

// File: rtl/tx_idle_timer.sv
// rtl/tx_idle_timer.sv - consecutive-idle counter with clear/enable; flags expiry at TIMEOUT_CYC-1
module tx_idle_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_expired;

    assign w_expired = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign o_expired = w_expired;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tx_fifo_to_dpram.sv
// rtl/tx_fifo_to_dpram.sv - drains the TX FIFO into the DM9000A transmit DPRAM from address 0 upward
// Optional zero padding of short frames up to MIN_FRAME is enabled by defining TX_PAD_EN.
module tx_fifo_to_dpram #(
    parameter int ADDR_W      = dm9000a_pkg::ADDR_W_DEF,
    parameter int MIN_FRAME   = dm9000a_pkg::MIN_FRAME,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              iDm9000aClk,
    input  logic              iRst,
    input  logic              iRunStart,
    input  logic [15:0]       iTxLen,
    output logic              oRunEnd,
    output logic [15:0]       oTxLen,
    output logic              oTimeout,
    input  logic              rdempty,
    output logic              rd_fifo_req,
    input  logic [7:0]        fifo_q,
    output logic              wren_b,
    output logic [ADDR_W-1:0] address_b,
    output logic [7:0]        data_b
);

    import dm9000a_pkg::*;

    if (MIN_FRAME >= (1 << ADDR_W)) begin : g_bad_min_frame
        $error("MIN_FRAME must be below 2**ADDR_W");
    end
    if (FIFO_RD_LAT != 1) begin : g_bad_rd_lat
        $error("single WAIT state assumes a 1-cycle FIFO read latency");
    end

    state_t            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_len, w_len_nx;
    logic [ADDR_W-1:0] r_count, w_count_nx;
    logic              r_run_end, w_run_end_nx;
    logic [15:0]       r_tx_len, w_tx_len_nx;
    logic              r_timeout, w_timeout_nx;
    logic              r_rd_req, w_rd_req_nx;
    logic              r_wren, w_wren_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic [7:0]        r_data, w_data_nx;
    logic              w_tmr_clr, w_tmr_en, w_tmr_exp;
    logic              w_close, w_short;
    logic [15-ADDR_W:0] w_unused_len;

    assign w_unused_len = iTxLen[15:ADDR_W];

`ifdef TX_PAD_EN
    assign w_short = (r_count < ADDR_W'(MIN_FRAME));
`else
    assign w_short = 1'b0;
`endif

    tx_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
        .i_clk     (iDm9000aClk),
        .i_rst     (iRst),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_tmr_exp)
    );

    always_comb begin
        w_state_nx   = r_state;
        w_len_nx     = r_len;
        w_count_nx   = r_count;
        w_run_end_nx = r_run_end;
        w_tx_len_nx  = r_tx_len;
        w_timeout_nx = r_timeout;
        w_rd_req_nx  = 1'b0;
        w_wren_nx    = 1'b0;
        w_addr_nx    = r_addr;
        w_data_nx    = r_data;
        w_tmr_clr    = 1'b0;
        w_tmr_en     = 1'b0;
        w_close      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iRunStart) begin
                    w_len_nx     = iTxLen[ADDR_W-1:0];
                    w_count_nx   = '0;
                    w_timeout_nx = 1'b0;
                    w_tmr_clr    = 1'b1;
                    w_state_nx   = ST_RD;
                end
            end
            ST_RD: begin
                // A pending byte beats a timeout that expires on the same cycle.
                if (r_count == r_len) begin
                    w_close = 1'b1;
                end else if (!rdempty) begin
                    w_rd_req_nx = 1'b1;
                    w_tmr_clr   = 1'b1;
                    w_state_nx  = ST_WAIT;
                end else if (w_tmr_exp) begin
                    w_timeout_nx = 1'b1;
                    w_close      = 1'b1;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_WAIT: w_state_nx = ST_WR;
            ST_WR: begin
                w_wren_nx  = 1'b1;
                w_addr_nx  = r_count;
                w_data_nx  = fifo_q;
                w_count_nx = r_count + 1'b1;
                w_state_nx = ST_RD;
            end
            ST_PAD: begin
`ifdef TX_PAD_EN
                if (w_short) begin
                    w_wren_nx  = 1'b1;
                    w_addr_nx  = r_count;
                    w_data_nx  = 8'h00;
                    w_count_nx = r_count + 1'b1;
                end else begin
                    w_state_nx   = ST_DONE;
                    w_run_end_nx = 1'b1;
                    w_tx_len_nx  = 16'(r_count);
                end
`else
                w_state_nx = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (!iRunStart) begin
                    w_state_nx   = ST_IDLE;
                    w_run_end_nx = 1'b0;
                    w_timeout_nx = 1'b0;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
        if (w_close) begin
            if (w_short) begin
                w_state_nx = ST_PAD;
            end else begin
                w_state_nx   = ST_DONE;
                w_run_end_nx = 1'b1;
                w_tx_len_nx  = 16'(r_count);
            end
        end
        // Losing iRunStart mid-frame abandons the frame; any byte already fetched is dropped.
        if (!iRunStart && (r_state inside {ST_RD, ST_WAIT, ST_WR, ST_PAD})) begin
            w_state_nx   = ST_IDLE;
            w_run_end_nx = 1'b0;
            w_tx_len_nx  = r_tx_len;
            w_timeout_nx = 1'b0;
            w_rd_req_nx  = 1'b0;
            w_wren_nx    = 1'b0;
            w_tmr_en     = 1'b0;
        end
    end

    always_ff @(posedge iDm9000aClk) begin
        if (iRst) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_count   <= '0;
            r_run_end <= 1'b0;
            r_tx_len  <= '0;
            r_timeout <= 1'b0;
            r_rd_req  <= 1'b0;
            r_wren    <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_len     <= w_len_nx;
            r_count   <= w_count_nx;
            r_run_end <= w_run_end_nx;
            r_tx_len  <= w_tx_len_nx;
            r_timeout <= w_timeout_nx;
            r_rd_req  <= w_rd_req_nx;
            r_wren    <= w_wren_nx;
            r_addr    <= w_addr_nx;
            r_data    <= w_data_nx;
        end
    end

    assign oRunEnd     = r_run_end;
    assign oTxLen      = r_tx_len;
    assign oTimeout    = r_timeout;
    assign rd_fifo_req = r_rd_req;
    assign wren_b      = r_wren;
    assign address_b   = r_addr;
    assign data_b      = r_data;

endmodule

// File: tb/tb_tx_fifo_to_dpram.sv
// tb/tb_tx_fifo_to_dpram.sv - scoreboard bench for tx_fifo_to_dpram with a FIFO model and DPRAM write monitor
module tb_tx_fifo_to_dpram;

`ifdef TX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        run_start;
    logic [15:0] tx_len;
    logic        run_end;
    logic [15:0] o_len;
    logic        timeout;
    logic        rdempty;
    logic        rd_req;
    logic [7:0]  fifo_q = 8'h00;
    logic        wren;
    logic [9:0]  addr;
    logic [7:0]  data;

    always #5 clk = ~clk;

    tx_fifo_to_dpram dut (
        .iDm9000aClk (clk),
        .iRst        (rst),
        .iRunStart   (run_start),
        .iTxLen      (tx_len),
        .oRunEnd     (run_end),
        .oTxLen      (o_len),
        .oTimeout    (timeout),
        .rdempty     (rdempty),
        .rd_fifo_req (rd_req),
        .fifo_q      (fifo_q),
        .wren_b      (wren),
        .address_b   (addr),
        .data_b      (data)
    );

    // FIFO model: normal-mode show-ahead-free, q updates on the edge that samples the request
    logic [7:0]  fifo_mem [0:2047];
    logic [10:0] wr_ptr = '0;
    logic [10:0] rd_ptr = '0;
    assign rdempty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (rd_req && !rdempty) begin
            fifo_q <= fifo_mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

    logic [17:0] exp_wr [$];
    logic [16:0] exp_done [$];
    int checks = 0;
    int failures = 0;
    int rd_pulses = 0;
    int last_addr = -1;
    logic prev_end = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        logic [17:0] ew;
        logic [16:0] ed;
        if (rd_req) rd_pulses++;
        if (wren) begin
            last_addr = int'(addr);
            if (exp_wr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h/%0h required=none", addr, data);
            end else begin
                ew = exp_wr.pop_front();
                check("wr_addr", 32'(addr), 32'(ew[17:8]));
                check("wr_data", 32'(data), 32'(ew[7:0]));
            end
        end
        if (run_end && !prev_end) begin
            if (exp_done.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_run_end actual=%0h required=none", o_len);
            end else begin
                ed = exp_done.pop_front();
                check("done_txlen", 32'(o_len), 32'(ed[15:0]));
                check("done_timeout", 32'(timeout), 32'(ed[16]));
            end
        end
        prev_end = run_end;
    end

    task automatic load(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr] = base + 8'(17 * i);
            wr_ptr = wr_ptr + 1'b1;
        end
    endtask

    task automatic expect_writes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) exp_wr.push_back({10'(i), base + 8'(17 * i)});
    endtask

    task automatic expect_pads(input int from);
        if (PAD) for (int i = from; i < 60; i++) exp_wr.push_back({10'(i), 8'h00});
    endtask

    task automatic wait_end(input int max, input string name, output int cyc);
        cyc = 0;
        while (!run_end && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        if (!run_end) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_run_end required=run_end_within_%0d", name, max);
        end
    endtask

    task automatic wait_write(input int a, input string name);
        int n;
        n = 0;
        while (!(wren && addr == 10'(a)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(wren && addr == 10'(a))) begin
            checks++;
            failures++;
            $display("FAIL %s_wait actual=no_write required=write_at_%0d", name, a);
        end
    endtask

    task automatic end_frame(input string name);
        run_start = 1'b0;
        @(negedge clk);
        check({name, "_runend_clear"}, 32'(run_end), 32'd0);
        check({name, "_queue_empty"}, exp_wr.size(), 0);
    endtask

    initial begin
        int cyc, p0;
        rst = 1'b1; run_start = 1'b0; tx_len = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_runend", 32'(run_end), 0);
        check("rst_txlen", 32'(o_len), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_rdreq", 32'(rd_req), 0);
        check("rst_wren", 32'(wren), 0);
        check("rst_addr", 32'(addr), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: four bytes A1 B2 C3 D4, then hold DONE for 50 cycles
        load(4, 8'hA1); expect_writes(4, 8'hA1); expect_pads(4);
        exp_done.push_back({1'b0, PAD ? 16'd60 : 16'd4});
        p0 = rd_pulses; tx_len = 16'd4; run_start = 1'b1;
        wait_end(200, "t1", cyc);
        check("t1_latency", cyc, PAD ? 71 : 14);
        check("t1_rd_pulses", rd_pulses - p0, 4);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("t1_hold_runend", 32'(run_end), 1);
            check("t1_hold_txlen", 32'(o_len), PAD ? 60 : 4);
        end
        end_frame("t1");

        // 2: 10 of 100 bytes supplied, frame closes on idle timeout
        load(10, 8'h10); expect_writes(10, 8'h10); expect_pads(10);
        exp_done.push_back({1'b1, PAD ? 16'd60 : 16'd10});
        tx_len = 16'd100; run_start = 1'b1;
        wait_end(1500, "t2", cyc);
        check("t2_latency", cyc, PAD ? 1106 : 1055);
        check("t2_timeout", 32'(timeout), 1);
        end_frame("t2");
        check("t2_timeout_clear", 32'(timeout), 0);

        // 3: maximum frame, last address 0x3FE
        load(1023, 8'h00); expect_writes(1023, 8'h00);
        exp_done.push_back({1'b0, 16'd1023});
        tx_len = 16'd1023; run_start = 1'b1;
        wait_end(4000, "t3", cyc);
        check("t3_latency", cyc, 3071);
        check("t3_last_addr", last_addr, 32'h3FE);
        end_frame("t3");

        // 4: zero length
        expect_pads(0);
        exp_done.push_back({1'b0, PAD ? 16'd60 : 16'd0});
        p0 = rd_pulses; tx_len = 16'd0; run_start = 1'b1;
        wait_end(100, "t4", cyc);
        check("t4_latency", cyc, PAD ? 63 : 2);
        check("t4_rd_pulses", rd_pulses - p0, 0);
        end_frame("t4");

        // 5: reset while in WR at count=5, then restart with 3 bytes
        load(10, 8'h50); expect_writes(5, 8'h50);
        tx_len = 16'd10; run_start = 1'b1;
        wait_write(4, "t5");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; run_start = 1'b0;
        @(negedge clk);
        check("t5_rst_wren", 32'(wren), 0);
        check("t5_rst_runend", 32'(run_end), 0);
        rst = 1'b0;
        wr_ptr = rd_ptr;
        repeat (5) @(negedge clk);
        check("t5_no_stray_write", exp_wr.size(), 0);
        load(3, 8'h70); expect_writes(3, 8'h70); expect_pads(3);
        exp_done.push_back({1'b0, PAD ? 16'd60 : 16'd3});
        tx_len = 16'd3; run_start = 1'b1;
        wait_end(200, "t5b", cyc);
        end_frame("t5b");

        // 6: abort at count=7
        load(20, 8'h90); expect_writes(7, 8'h90);
        p0 = rd_pulses; tx_len = 16'd20; run_start = 1'b1;
        wait_write(6, "t6");
        run_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t6_runend_low", 32'(run_end), 0);
        end
        check("t6_rd_pulses", rd_pulses - p0, 7);
        check("t6_queue_empty", exp_wr.size(), 0);
        wr_ptr = rd_ptr;
        check("done_queue_empty", exp_done.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
